// File: rtl/led_pkg.sv
// Shared LED-mode and key-FSM encodings, used by key_mode_sel and the
// downstream LED mode multiplexer.
package led_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BLINK  = 2'b00,
    MODE_FLOW   = 2'b01,
    MODE_HORSE  = 2'b10,
    MODE_BREATH = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PRESS_DB = 2'b01,
    ST_HELD     = 2'b10,
    ST_REL_DB   = 2'b11
  } key_state_t;

  // Cyclic step through the four modes; BREATH wraps back to BLINK.
  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(MODE_W'(m + 1'b1));
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer for the raw key plus the shared stability counter,
// which the key FSM clears or advances each cycle.
module key_debounce #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             key_in,
  input  logic             cnt_clr,
  input  logic             cnt_inc,
  output logic             key_s,
  output logic [CNT_W-1:0] cnt
);

  logic sync_q;

  // Flops reset to 1 so an idle (released) key is seen right after reset.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b1;
      key_s  <= 1'b1;
    end else begin
      sync_q <= key_in;
      key_s  <= sync_q;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/key_mode_sel.sv
// Debounced push-button mode selector: each confirmed press steps the LED
// mode, a long hold forces BLINK.
module key_mode_sel
  import led_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              key_in,
  output logic [MODE_W-1:0] mode,
  output logic              mode_chg,
  output logic              key_pressed
);

  localparam int unsigned DB_CYC   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned LONG_CYC = CLK_FREQ / 1000 * LONG_MS;
  localparam int unsigned CNT_W    = $clog2(LONG_CYC + 1);

  logic             key_s;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr_c;
  logic             cnt_inc_c;
  logic             db_hit_c;
  logic             long_hit_c;

  key_state_t state;
  mode_t      mode_q;
  logic       long_done;

  key_debounce #(
    .CNT_W (CNT_W)
  ) u_key_debounce (
    .sys_clk (sys_clk),
    .rst     (rst),
    .key_in  (key_in),
    .cnt_clr (cnt_clr_c),
    .cnt_inc (cnt_inc_c),
    .key_s   (key_s),
    .cnt     (cnt)
  );

  // Hit flags fire on the cycle whose increment would reach N-1.
  assign db_hit_c   = (cnt == CNT_W'(DB_CYC - 2));
  assign long_hit_c = (cnt == CNT_W'(LONG_CYC - 2));

  always_comb begin
    cnt_clr_c = 1'b0;
    cnt_inc_c = 1'b0;
    unique case (state)
      ST_IDLE:     cnt_clr_c = 1'b1;
      ST_PRESS_DB: begin
        if (key_s || db_hit_c) cnt_clr_c = 1'b1;
        else                   cnt_inc_c = 1'b1;
      end
      ST_HELD: begin
        if (key_s)           cnt_clr_c = 1'b1;
        else if (!long_done) cnt_inc_c = 1'b1;
      end
      ST_REL_DB: begin
        if (!key_s || db_hit_c) cnt_clr_c = 1'b1;
        else                    cnt_inc_c = 1'b1;
      end
      default:     cnt_clr_c = 1'b1;
    endcase
  end

  // long_done survives release bounces so a long press forces BLINK once.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      mode_q      <= MODE_BLINK;
      mode_chg    <= 1'b0;
      key_pressed <= 1'b0;
      long_done   <= 1'b0;
    end else begin
      mode_chg <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!key_s) state <= ST_PRESS_DB;
        end
        ST_PRESS_DB: begin
          if (key_s) begin
            state <= ST_IDLE;
          end else if (db_hit_c) begin
            state       <= ST_HELD;
            mode_q      <= next_mode(mode_q);
            mode_chg    <= 1'b1;
            key_pressed <= 1'b1;
            long_done   <= 1'b0;
          end
        end
        ST_HELD: begin
          if (key_s) begin
            state <= ST_REL_DB;
          end else if (!long_done && long_hit_c) begin
            long_done <= 1'b1;
            if (mode_q != MODE_BLINK) begin
              mode_q   <= MODE_BLINK;
              mode_chg <= 1'b1;
            end
          end
        end
        ST_REL_DB: begin
          if (!key_s) begin
            state <= ST_HELD;
          end else if (db_hit_c) begin
            state       <= ST_IDLE;
            key_pressed <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_key_mode_sel.sv
// Bench for key_mode_sel: directed key scenarios plus random key traffic,
// checked every cycle against a run-length model of the press rules.
module tb_key_mode_sel;

  localparam int unsigned DB   = 20;
  localparam int unsigned LONG = 100;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic [1:0] mode;
  logic       mode_chg;
  logic       key_pressed;

  key_mode_sel #(
    .CLK_FREQ    (10_000),
    .DEBOUNCE_MS (2),
    .LONG_MS     (10)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .key_in      (key_in),
    .mode        (mode),
    .mode_chg    (mode_chg),
    .key_pressed (key_pressed)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int chg_cnt = 0;
  int first_chg = 0;
  int last_chg  = 0;

  // Reference model state: synchronizer taps and run lengths of key_s levels.
  logic       s1, s2;
  int         low_run, high_run, long_run;
  bit         pressed, long_done;
  logic [1:0] m_mode;
  logic       m_chg, m_pressed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    s1 = 1'b1; s2 = 1'b1;
    low_run = 0; high_run = 0; long_run = 0;
    pressed = 0; long_done = 0;
    m_mode = 2'b00; m_chg = 1'b0; m_pressed = 1'b0;
  endtask

  // One clock edge: a press needs DB low samples of key_s, a release DB high
  // samples, and the long hold LONG-1 further low samples while pressed.
  task automatic model_edge();
    logic ks;
    if (rst) begin
      model_reset();
      return;
    end
    ks = s2; s2 = s1; s1 = key_in;
    m_chg = 1'b0;
    if (!pressed) begin
      if (ks == 1'b0) begin
        low_run++;
        if (low_run == DB) begin
          pressed = 1; low_run = 0; high_run = 0; long_run = 0; long_done = 0;
          m_mode = m_mode + 2'd1;
          m_chg = 1'b1;
        end
      end else begin
        low_run = 0;
      end
    end else if (ks == 1'b1) begin
      high_run++;
      long_run = 0;
      if (high_run == DB) begin
        pressed = 0; high_run = 0; low_run = 0;
      end
    end else if (high_run > 0) begin
      high_run = 0;
      long_run = 0;
    end else begin
      long_run++;
      if (!long_done && long_run == LONG - 1) begin
        long_done = 1;
        if (m_mode != 2'b00) begin
          m_mode = 2'b00;
          m_chg = 1'b1;
        end
      end
    end
    m_pressed = pressed;
  endtask

  task automatic step(input logic k);
    key_in = k;
    @(posedge sys_clk);
    model_edge();
    #1;
    cyc++;
    if (mode_chg === 1'b1) begin
      chg_cnt++;
      if (first_chg == 0) first_chg = cyc;
      last_chg = cyc;
    end
    check("mode", 32'(mode), 32'(m_mode));
    check("mode_chg", 32'(mode_chg), 32'(m_chg));
    check("key_pressed", 32'(key_pressed), 32'(m_pressed));
  endtask

  task automatic run(input logic k, input int n);
    for (int i = 0; i < n; i++) step(k);
  endtask

  task automatic mark();
    chg_cnt = 0;
    first_chg = 0;
    last_chg = 0;
  endtask

  initial begin
    int start;
    int len;
    logic lvl;

    rst = 1'b1;
    key_in = 1'b1;
    model_reset();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_chg", 32'(mode_chg), 32'd0);
    check("reset_pressed", 32'(key_pressed), 32'd0);
    rst = 1'b0;

    // Idle key: nothing happens.
    mark();
    run(1'b1, 200);
    check("idle_chg_count", 32'(chg_cnt), 32'd0);
    check("idle_mode", 32'(mode), 32'd0);

    // Four clean presses walk the modes and wrap.
    for (int p = 0; p < 4; p++) begin
      mark();
      start = cyc;
      run(1'b0, 50);
      check("press_latency", 32'(first_chg - start), 32'd22);
      run(1'b1, 50);
      check("press_chg_count", 32'(chg_cnt), 32'd1);
      check("press_mode", 32'(mode), 32'((p + 1) % 4));
    end

    // Bouncing key never stays low long enough; then a real 30-cycle press.
    mark();
    for (int i = 0; i < 60; i++) step(((i / 5) % 2 == 0) ? 1'b0 : 1'b1);
    run(1'b1, 30);
    check("bounce_chg_count", 32'(chg_cnt), 32'd0);
    check("bounce_mode", 32'(mode), 32'd0);
    mark();
    run(1'b0, 30);
    run(1'b1, 40);
    check("after_bounce_chg", 32'(chg_cnt), 32'd1);
    check("after_bounce_mode", 32'(mode), 32'd1);

    // Reach HORSE, then long hold: BREATH then BLINK.
    run(1'b0, 30);
    run(1'b1, 40);
    check("pre_long_mode", 32'(mode), 32'd2);
    mark();
    start = cyc;
    run(1'b0, 150);
    check("long_chg_count", 32'(chg_cnt), 32'd2);
    check("long_first_lat", 32'(first_chg - start), 32'd22);
    check("long_second_lat_ok", 32'((last_chg - start >= 118) && (last_chg - start <= 124)), 32'd1);
    check("long_mode", 32'(mode), 32'd0);
    mark();
    for (int i = 0; i < 10; i++) step(((i / 2) % 2 == 0) ? 1'b1 : 1'b0);
    run(1'b1, 40);
    check("rel_bounce_chg", 32'(chg_cnt), 32'd0);
    check("rel_bounce_mode", 32'(mode), 32'd0);

    // Reset in the middle of a debounce with the key still held.
    run(1'b0, 30);
    run(1'b1, 40);
    check("pre_rst_mode", 32'(mode), 32'd1);
    run(1'b0, 12);
    @(negedge sys_clk);
    rst = 1'b1;
    #1;
    check("rst_mode_now", 32'(mode), 32'd0);
    check("rst_pressed_now", 32'(key_pressed), 32'd0);
    run(1'b0, 3);
    @(negedge sys_clk);
    rst = 1'b0;
    mark();
    start = cyc;
    run(1'b0, 40);
    check("post_rst_latency", 32'(first_chg - start), 32'd22);
    check("post_rst_mode", 32'(mode), 32'd1);
    run(1'b1, 40);

    // Random key traffic: mostly short segments, some long holds.
    while (cyc < 4000) begin
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 150))
                                        : int'($urandom_range(1, 25));
      run(lvl, len);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_mode_sel.md
KEY_MODE_SEL -- requirements
Module: key_mode_sel

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning sys_clk frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 20, meaning required key stability time in ms.
REQ-003 SHALL have parameter LONG_MS, default 1000, meaning hold time in ms that forces mode 0.
REQ-004 SHALL have port sys_clk  input  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port key_in  input  1  raw push-button, active-low (0 = pressed), asynchronous to sys_clk.
REQ-007 SHALL have port mode  output  2  selected LED mode; 00 blink, 01 flow, 10 horse, 11 breath.
REQ-008 SHALL have port mode_chg  output  1  one-cycle pulse in the cycle mode takes a new value.
REQ-009 SHALL have port key_pressed  output  1  debounced key level, 1 while a press is confirmed.

Function
REQ-010 SHALL pass key_in through a 2-flop synchronizer; all later logic uses only the synchronized level key_s.
REQ-011 SHALL derive DB_CYC = CLK_FREQ/1000*DEBOUNCE_MS and LONG_CYC = CLK_FREQ/1000*LONG_MS; counter width = clog2(LONG_CYC+1).
REQ-012 SHALL implement FSM states IDLE, PRESS_DB, HELD, REL_DB.
REQ-013 IDLE: key_s=0 -> PRESS_DB with counter cleared; otherwise stay.
REQ-014 PRESS_DB: counter increments each cycle key_s=0; key_s=1 on any cycle -> IDLE, counter cleared; counter reaching DB_CYC-1 with key_s=0 -> HELD.
REQ-015 On the PRESS_DB->HELD transition mode SHALL increment modulo 4 (11 wraps to 00) and mode_chg SHALL pulse in the same cycle mode updates.
REQ-016 HELD: counter continues from 0; reaching LONG_CYC-1 with key_s=0 SHALL set mode to 00 once per press, pulsing mode_chg only if mode was not already 00; key_s=1 -> REL_DB, counter cleared.
REQ-017 REL_DB: key_s=1 for DB_CYC consecutive cycles -> IDLE; key_s=0 on any cycle -> HELD without a mode change and without restarting the long-press count already satisfied.
REQ-018 key_pressed SHALL be 1 in HELD and REL_DB, 0 in IDLE and PRESS_DB.
REQ-019 Latency: mode SHALL change exactly 2 (sync) + DB_CYC cycles after a clean key_in falling edge.
REQ-020 Glitches shorter than DB_CYC cycles on press or release SHALL produce no mode change and no mode_chg.
REQ-021 All outputs SHALL be registered; mode holds its value indefinitely between valid presses.

Reset
REQ-022 rst asserted SHALL immediately force FSM to IDLE, counter to 0, synchronizer flops to 1, mode to 00, mode_chg to 0, key_pressed to 0.
REQ-023 rst asserted mid-press SHALL abort the press; after release of rst with key still held, a full PRESS_DB interval SHALL elapse before any mode change.
REQ-024 rst deassertion SHALL be synchronized externally; block does no reset synchronization.

Structure
REQ-025 Mode encodings (MODE_BLINK..MODE_BREATH) and FSM state encodings SHALL live in shared package led_pkg, reused by the LED mode multiplexer downstream.
REQ-026 Synchronizer + stability counter SHALL be sub-module key_debounce; key_mode_sel instantiates it and holds the FSM and mode register.
REQ-027 mode SHALL connect directly to the downstream multiplexer's 2-bit select input.

Verification (bench parameters CLK_FREQ=10_000, DEBOUNCE_MS=2, LONG_MS=10 -> DB_CYC=20, LONG_CYC=100)
REQ-028 Reset, key_in=1 for 200 cycles -> mode=00, mode_chg never 1, key_pressed=0.
REQ-029 Four clean presses of 50 cycles, 50 cycles apart -> mode 01,10,11,00, one mode_chg pulse each, 22 cycles after each falling edge.
REQ-030 Bounce: key_in toggles every 5 cycles for 60 cycles then settles at 1 -> no mode change; then held low 30 cycles -> exactly one increment.
REQ-031 From mode=10, hold key 150 cycles -> mode 11 at cycle 22, mode 00 at ~cycle 122, two mode_chg pulses total; release bounce of 10 cycles -> no further change.
REQ-032 Assert rst at cycle 10 of PRESS_DB with key held -> mode=00 immediately; deassert rst with key held -> mode=01 after 22 further cycles.
